// File: rtl/sum_group_accumulator_if.sv
// Handshake bundle for the group accumulator: upstream word stream in,
// group totals out, each with a valid/ready pair.
interface sum_group_accumulator_if #(
    parameter int width = 8,
    parameter int n     = 4
);
    localparam int out_width = width + $clog2(n);

    logic                 up_valid;
    logic                 up_ready;
    logic [width-1:0]     up_data;
    logic                 down_valid;
    logic                 down_ready;
    logic [out_width-1:0] down_data;

    // Accumulator side.
    modport slave (
        input  up_valid,
        input  up_data,
        output up_ready,
        output down_valid,
        output down_data,
        input  down_ready
    );

    // Producer/consumer side.
    modport master (
        output up_valid,
        output up_data,
        input  up_ready,
        input  down_valid,
        input  down_data,
        output down_ready
    );
endinterface

// File: rtl/sum_group_accumulator.sv
// Sums every n consecutive accepted words into one registered total, with a
// single-entry output stage that can be refilled in the same cycle it drains.
module sum_group_accumulator #(
    parameter int width = 8,
    parameter int n     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sum_group_accumulator_if.slave bus
);
    localparam int out_width = width + $clog2(n);
    localparam int cnt_width = $clog2(n);
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(n - 1);

    logic [out_width-1:0] acc_reg, acc_next;
    logic [cnt_width-1:0] cnt_reg, cnt_next;
    logic [out_width-1:0] down_data_reg, down_data_next;
    logic                 down_valid_reg, down_valid_next;

    logic                 up_ready;
    logic                 up_fire;
    logic                 pop;
    logic [out_width-1:0] sum;

    // Ready only looks at the output stage, so the producer never waits on
    // its own valid.
    assign up_ready = !down_valid_reg || bus.down_ready;
    assign up_fire  = bus.up_valid && up_ready;
    assign pop      = down_valid_reg && bus.down_ready;
    assign sum      = acc_reg + out_width'(bus.up_data);

    always_comb begin
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        down_data_next  = down_data_reg;
        down_valid_next = down_valid_reg;

        if (pop) begin
            down_valid_next = 1'b0;
        end

        // A group-completing accept overrides the pop, giving back-to-back totals.
        if (up_fire) begin
            if (cnt_reg == cnt_last) begin
                down_data_next  = sum;
                down_valid_next = 1'b1;
                acc_next        = '0;
                cnt_next        = '0;
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + cnt_width'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            down_data_reg  <= '0;
            down_valid_reg <= 1'b0;
        end else begin
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            down_data_reg  <= down_data_next;
            down_valid_reg <= down_valid_next;
        end
    end

    assign bus.up_ready   = up_ready;
    assign bus.down_valid = down_valid_reg;
    assign bus.down_data  = down_data_reg;
endmodule

// File: tb/tb_sum_group_accumulator.sv
// Directed and randomised bench for sum_group_accumulator (width=8, n=4) with
// a queue-based reference model checked every cycle.
module tb_sum_group_accumulator;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sum_group_accumulator_if #(.width(W), .n(N)) bus ();

    sum_group_accumulator #(.width(W), .n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: accepted words are gathered into groups of N; each full
    // group's sum waits in exp_q until the consumer takes it.
    logic [31:0] part_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] popped_log[$];
    logic [31:0] last_total = '0;
    bit          started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] s;
        logic [31:0] want_data;
        logic        want_pop;
        if (rst) begin
            started = 1'b1;
            part_q.delete();
            exp_q.delete();
            last_total = '0;
        end else if (started) begin
            want_data = (exp_q.size() != 0) ? exp_q[0] : last_total;
            chk("down_valid", 32'(bus.down_valid), 32'(exp_q.size() != 0));
            chk("down_data", 32'(bus.down_data), want_data);
            chk("up_ready", 32'(bus.up_ready), 32'((exp_q.size() == 0) || bus.down_ready));
            want_pop = (exp_q.size() != 0) && bus.down_ready;
            if (want_pop) begin
                last_total = exp_q.pop_front();
                popped_log.push_back(last_total);
            end
            if (bus.up_valid && bus.up_ready) begin
                part_q.push_back(32'(bus.up_data));
                if (part_q.size() == N) begin
                    s = 0;
                    foreach (part_q[i]) s += part_q[i];
                    exp_q.push_back(s);
                    part_q.delete();
                end
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        int t = 0;
        bus.up_valid = 1'b1;
        bus.up_data  = w;
        @(negedge clk);
        while (!bus.up_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept word=%0d", w);
        end
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        bus.up_data  = W'($urandom);
    endtask

    initial begin
        int idx;
        int sent;
        int cyc;
        bit fire;

        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.down_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_up_ready", 32'(bus.up_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_down_valid", 32'(bus.down_valid), 32'd0);
        chk("rst_down_data", 32'(bus.down_data), 32'd0);
        idle(1);

        // Basic sum: total 10 for exactly one cycle.
        idx = popped_log.size();
        send(1); send(2); send(3); send(4);
        @(negedge clk);
        chk("basic_valid", 32'(bus.down_valid), 32'd1);
        chk("basic_data", 32'(bus.down_data), 32'd10);
        @(negedge clk);
        chk("basic_one_cycle", 32'(bus.down_valid), 32'd0);
        idle(2);
        chk("basic_log", popped_log[idx], 32'd10);

        // Full-scale words: no truncation of the 10-bit total.
        idx = popped_log.size();
        send(255); send(255); send(255); send(255);
        idle(3);
        chk("width_total", popped_log[idx], 32'd1020);

        // Backpressure: total held and up_ready low while the consumer stalls.
        bus.down_ready = 1'b0;
        send(10); send(20); send(30); send(40);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.down_valid), 32'd1);
            chk("bp_data", 32'(bus.down_data), 32'd100);
            chk("bp_up_ready", 32'(bus.up_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.down_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.up_ready), 32'd1);
        @(negedge clk);
        chk("bp_popped", 32'(bus.down_valid), 32'd0);
        chk("bp_log", popped_log[popped_log.size()-1], 32'd100);
        idle(1);

        // Streaming: two totals back-to-back.
        idx = popped_log.size();
        for (int i = 1; i <= 8; i++) send(W'(i));
        idle(3);
        chk("stream_count", 32'(popped_log.size() - idx), 32'd2);
        chk("stream_first", popped_log[idx], 32'd10);
        chk("stream_second", popped_log[idx+1], 32'd26);

        // Gaps then reset mid-group: partial 5+6 and the reset-cycle word vanish.
        idx = popped_log.size();
        send(5);
        idle(2);
        send(6);
        idle(2);
        rst = 1'b1;
        bus.up_valid = 1'b1;
        bus.up_data  = 9;
        @(negedge clk);
        chk("rst_mid_up_ready", 32'(bus.up_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.up_valid = 1'b0;
        send(1); send(1); send(1); send(1);
        idle(3);
        chk("reset_count", 32'(popped_log.size() - idx), 32'd1);
        chk("reset_total", popped_log[idx], 32'd4);

        // Random traffic: 1000 words, 50% valid and 50% ready.
        idx  = popped_log.size();
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (!bus.up_valid) begin
                bus.up_data = W'($urandom);
                if ($urandom_range(0, 1) == 1) bus.up_valid = 1'b1;
            end
            bus.down_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            fire = bus.up_valid && bus.up_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                sent++;
                bus.up_valid = 1'b0;
            end
            cyc++;
        end
        bus.up_valid   = 1'b0;
        bus.down_ready = 1'b1;
        idle(5);
        chk("random_words", 32'(sent), 32'd1000);
        chk("random_totals", 32'(popped_log.size() - idx), 32'd250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
